// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types and constants (receiver, receive FIFO and the
//            transmitter side all import this package).
// Contents : rx_entry_t  - one received byte plus its error tags
//            RX_ENTRY_W  - packed width of rx_entry_t
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int RX_ENTRY_W = 10;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_mem
// Purpose  : DEPTH x WIDTH register array with one synchronous write port and
//            one combinational read port. No reset: occupancy is tracked by
//            the owner, so stale contents are never observed.
// Ports    : clk      - clock
//            wr_en    - write strobe
//            wr_addr  - write address
//            wr_data  - write data
//            rd_addr  - read address
//            rd_data  - read data (combinational from rd_addr)
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = RX_ENTRY_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive-side buffer behind the UART receiver. Turns the
//            receiver's level-held status into single-cycle frame events,
//            tags each byte with parity/frame error, and buffers entries in a
//            first-word-fall-through FIFO with a valid/ready read port.
//            Overflow drops are flagged (sticky) and counted.
// Ports    : clk, rst_n (async, active-low)
//            rx_data, rx_valid, parity_error, frame_error - receiver side
//            m_valid, m_ready, m_data, m_parity_err, m_frame_err - read port
//            level, almost_full - occupancy status
//            overflow, ovf_clr, drop_cnt - overflow flag / clear / counter
//            err_cnt - errored entries discarded (DROP_ERRORED=1 only)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AF_THRESH    = 12,
    parameter int DROP_ERRORED = 0,
    parameter int CNT_W        = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     parity_error,
    input  logic                     frame_error,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [7:0]               m_data,
    output logic                     m_parity_err,
    output logic                     m_frame_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] c_full_lvl = LW'(DEPTH);
    localparam logic [LW-1:0] c_af_lvl   = LW'(AF_THRESH);

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic      r_rv_q;
    logic      r_fe_q;
    logic      r_rv_arm;
    logic      r_fe_arm;
    logic      r_evt;
    rx_entry_t r_entry;
    logic      w_evt;
    rx_entry_t w_entry;

    // The arm flags stay low after reset until each status line has been seen
    // low once, so a level still held from before reset cannot masquerade as
    // a fresh rising edge.
    assign w_evt = (rx_valid    & ~r_rv_q & r_rv_arm)
                 | (frame_error & ~r_fe_q & r_fe_arm);

    assign w_entry.frame_err  = frame_error;
    assign w_entry.parity_err = parity_error;
    assign w_entry.data       = rx_data;

    // The entry is captured on the event cycle and written one cycle later;
    // this keeps the write decision off the asynchronous receiver inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rv_q   <= 1'b0;
            r_fe_q   <= 1'b0;
            r_rv_arm <= 1'b0;
            r_fe_arm <= 1'b0;
            r_evt    <= 1'b0;
            r_entry  <= '0;
        end else begin
            r_rv_q   <= rx_valid;
            r_fe_q   <= frame_error;
            r_rv_arm <= r_rv_arm | ~rx_valid;
            r_fe_arm <= r_fe_arm | ~frame_error;
            r_evt    <= w_evt;
            if (w_evt) begin
                r_entry <= w_entry;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write / read control
    // ------------------------------------------------------------------
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_full;
    logic          w_pop;
    logic          w_err;
    logic          w_discard;
    logic          w_push;
    logic          w_drop;
    rx_entry_t     w_head;

    assign w_full    = (r_level == c_full_lvl);
    assign w_pop     = m_valid & m_ready;
    assign w_err     = r_entry.frame_err | r_entry.parity_err;
    assign w_discard = r_evt & (DROP_ERRORED != 0) & w_err;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push    = r_evt & ~w_discard & (~w_full | w_pop);
    assign w_drop    = r_evt & ~w_discard & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Overflow flag and saturating counters
    // ------------------------------------------------------------------
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            // A drop coinciding with a clear leaves a count of exactly one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (ovf_clr) begin
                    r_drop_cnt <= CNT_W'(1);
                end else if (!(&r_drop_cnt)) begin
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                end
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
            if (w_discard && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [RX_ENTRY_W-1:0] w_rd_word;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (r_entry),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_word)
    );

    assign w_head = w_rd_word;

    // ------------------------------------------------------------------
    // Outputs; head fields are forced to zero while empty.
    // ------------------------------------------------------------------
    assign m_valid      = (r_level != '0);
    assign m_data       = m_valid ? w_head.data       : 8'h00;
    assign m_parity_err = m_valid ? w_head.parity_err : 1'b0;
    assign m_frame_err  = m_valid ? w_head.frame_err  : 1'b0;
    assign level        = r_level;
    assign almost_full  = (r_level >= c_af_lvl);
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;
    assign err_cnt      = r_err_cnt;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo. Two instances
//            share one stimulus: dut (DROP_ERRORED=0) and dut_de
//            (DROP_ERRORED=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_error;
    logic       frame_error;
    logic       m_ready;
    logic       ovf_clr;

    logic       m_valid,   de_m_valid;
    logic [7:0] m_data,    de_m_data;
    logic       m_pe,      de_m_pe;
    logic       m_fe,      de_m_fe;
    logic [4:0] level,     de_level;
    logic       af,        de_af;
    logic       ovf,       de_ovf;
    logic [7:0] drop_cnt,  de_drop_cnt;
    logic [7:0] err_cnt,   de_err_cnt;

    int vectors;
    int miscompares;

    uart_rx_fifo #(.DEPTH(16), .AF_THRESH(12), .DROP_ERRORED(0), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_error(parity_error), .frame_error(frame_error),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_parity_err(m_pe), .m_frame_err(m_fe), .level(level),
        .almost_full(af), .overflow(ovf), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    uart_rx_fifo #(.DEPTH(16), .AF_THRESH(12), .DROP_ERRORED(1), .CNT_W(8)) dut_de (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_error(parity_error), .frame_error(frame_error),
        .m_valid(de_m_valid), .m_ready(m_ready), .m_data(de_m_data),
        .m_parity_err(de_m_pe), .m_frame_err(de_m_fe), .level(de_level),
        .almost_full(de_af), .overflow(de_ovf), .ovf_clr(ovf_clr),
        .drop_cnt(de_drop_cnt), .err_cnt(de_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One receiver frame: status rises for a cycle, then falls. The entry is
    // written at the second edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic fe);
        rx_data = d; parity_error = pe; frame_error = fe; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; parity_error = 1'b0; frame_error = 1'b0;
        tick();
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_b;

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; parity_error = 1'b0;
        frame_error = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_m_valid",  m_valid, 0);
        chk("rst_level",    level, 0);
        chk("rst_af",       af, 0);
        chk("rst_ovf",      ovf, 0);
        chk("rst_drop",     drop_cnt, 0);
        chk("rst_err",      de_err_cnt, 0);
        chk("rst_m_data",   m_data, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Held rx_valid: one entry, latency N+1
        rx_data = 8'hA5; rx_valid = 1'b1;
        tick();
        chk("lat_edgeN_m_valid", m_valid, 0);
        tick();
        chk("lat_edgeN1_m_valid", m_valid, 1);
        chk("held_m_data", m_data, 8'hA5);
        chk("held_tags", {m_fe, m_pe}, 0);
        repeat (18) tick();
        chk("held_level", level, 1);
        rx_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("pop_level", level, 0);
        chk("pop_m_valid", m_valid, 0);
        chk("empty_m_data", m_data, 0);
        tick();

        // Parity error then rx_valid
        parity_error = 1'b1; rx_data = 8'h3C;
        tick();
        chk("pe_alone_no_evt", level, 0);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; parity_error = 1'b0;
        tick();
        chk("pe_level", level, 1);
        chk("pe_entry", {m_fe, m_pe, m_data}, {2'b01, 8'h3C});
        chk("de_pe_level", de_level, 0);
        chk("de_pe_errcnt", de_err_cnt, 1);

        // Frame error alone
        send(8'h00, 1'b0, 1'b1);
        chk("fe_level", level, 2);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("fe_entry", {m_fe, m_pe, m_data}, {2'b10, 8'h00});
        chk("de_fe_errcnt", de_err_cnt, 2);
        chk("de_fe_level", de_level, 0);
        chk("de_fe_ovf", de_ovf, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Coincident rising edges: one entry, frame tag set
        rx_data = 8'h77; rx_valid = 1'b1; frame_error = 1'b1;
        tick();
        rx_valid = 1'b0; frame_error = 1'b0;
        tick();
        chk("both_level", level, 1);
        chk("both_entry", {m_fe, m_data}, {1'b1, 8'h77});
        chk("de_both_errcnt", de_err_cnt, 3);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("both_drained", level, 0);

        // Fill to full and overflow
        for (int i = 0; i < 17; i++) begin
            send(8'(i), 1'b0, 1'b0);
            if (i == 10) chk("af_at_11", af, 0);
            if (i == 11) chk("af_at_12", af, 1);
        end
        chk("full_level", level, 16);
        chk("full_ovf", ovf, 1);
        chk("full_drop", drop_cnt, 1);
        chk("de_full_drop", de_drop_cnt, 1);

        // Event and pop in the same cycle while full
        chk("full_head", m_data, 8'h00);
        rx_data = 8'hEE; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("fullpop_level", level, 16);
        chk("fullpop_drop", drop_cnt, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", ovf, 0);
        chk("clr_drop", drop_cnt, 0);

        // Drain: 0x01..0x0F then 0xEE
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp_b = (i == 16) ? 8'hEE : 8'(i);
            chk("drain_data", m_data, exp_b);
            tick();
        end
        m_ready = 1'b0;
        chk("drain_level", level, 0);

        // Interleaved push/pop across pointer wrap
        for (int i = 0; i < 40; i++) begin
            m_ready = i[0];
            rx_data = 8'h40 + 8'(i); rx_valid = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (m_valid && m_ready) begin
                    if (q.size() == 0) chk("wrap_spurious", m_valid, 0);
                    else chk("wrap_order", m_data, q.pop_front());
                end
                tick();
                rx_valid = 1'b0;
                if (level > 16) chk("wrap_level_max", level, 16);
            end
            q.push_back(8'h40 + 8'(i));
        end
        m_ready = 1'b1;
        for (int k = 0; k < 20 && m_valid; k++) begin
            if (q.size() == 0) chk("wrap_spurious", m_valid, 0);
            else chk("wrap_order", m_data, q.pop_front());
            tick();
        end
        m_ready = 1'b0;
        chk("wrap_empty", level, 0);
        chk("wrap_q_empty", q.size(), 0);

        // Reset with contents and rx_valid held high
        for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), 1'b0, 1'b0);
        chk("pre_rst_level", level, 5);
        rx_data = 8'hC3; rx_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", level, 0);
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_ovf", ovf, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_no_evt", level, 0);
        rx_valid = 1'b0;
        tick();
        rx_data = 8'h5A; rx_valid = 1'b1;
        repeat (2) tick();
        chk("post_rst_evt_level", level, 1);
        chk("post_rst_evt_data", m_data, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver.
- Converts the receiver's level-held status outputs into single-cycle frame events.
- Tags each received byte with its parity and frame error status.
- Buffers entries in a first-word-fall-through FIFO with a valid/ready read port for the host or bus bridge.
- Flags and counts overflow drops.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH.
DROP_ERRORED, 0, when 1, entries with a parity or frame error are discarded and counted instead of stored.
CNT_W, 8, width of the saturating drop and error counters.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_data  in  8  receiver data byte
rx_valid  in  1  receiver good-stop indication; held high until the next start bit
parity_error  in  1  receiver parity flag; level-held
frame_error  in  1  receiver frame flag; level-held
m_valid  out  1  head entry available
m_ready  in  1  consumer accepts head entry
m_data  out  8  head entry data byte
m_parity_err  out  1  head entry parity error tag
m_frame_err  out  1  head entry frame error tag
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  out  1  level >= AF_THRESH
overflow  out  1  sticky; set when an event is dropped because the FIFO is full
ovf_clr  in  1  synchronous clear of overflow and drop_cnt
drop_cnt  out  CNT_W  saturating count of events dropped on full
err_cnt  out  CNT_W  saturating count of errored events discarded when DROP_ERRORED=1

Behaviour:
Reset values (all asynchronous):
- m_valid=0, level=0, almost_full=0, overflow=0, drop_cnt=0, err_cnt=0.
- m_data, m_parity_err and m_frame_err read 0 while empty.
- Edge-detect registers cleared; pointers reset to 0.
- Reset during an active frame discards all stored contents.

Event detection:
- rv_q and fe_q register rx_valid and frame_error each cycle.
- evt = (rx_valid & ~rv_q) | (frame_error & ~fe_q).
- A level held across many cycles produces exactly one event.
- Entry on event = {frame_error, parity_error, rx_data}, sampled on the event cycle.
- If both rising edges coincide, one entry is written with the frame error tag set.

Write:
- On evt, the entry is written when not full, or when full and a pop occurs in the same cycle.
- In the full-with-pop case the push is accepted and level is unchanged.
- When full with no pop: entry dropped, overflow set to 1, drop_cnt incremented, saturating at 2^CNT_W-1.
- When DROP_ERRORED=1 and the entry has any error bit set: entry not written, err_cnt incremented (saturating), overflow unaffected.

Read (first-word-fall-through):
- m_valid = (level != 0); m_data and the tags come directly from the head entry.
- Pop occurs when m_valid & m_ready. m_ready while empty has no effect.
- m_valid, m_data and tags must stay stable until the pop.

Latency:
- If the FIFO is empty and rx_valid is first sampled high at edge N, m_valid is high after edge N+1.
- Back-to-back pushes are accepted one per cycle.

Level arithmetic:
- level +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Full is level==DEPTH.

Clearing:
- ovf_clr clears overflow and drop_cnt.
- If ovf_clr coincides with a drop, the drop wins: overflow=1, drop_cnt=1.

Decomposition:
- uart_pkg holds the rx_entry_t packed struct {frame_err, parity_err, data[7:0]} and the RX_ENTRY_W constant.
- uart_pkg is shared with the receiver and future transmitter.
- One sub-module, uart_fifo_mem: DEPTH x RX_ENTRY_W register array with a synchronous write port and a combinational read port.
- Pointers, level, counters and edge detection live in uart_rx_fifo.

Test Plan:
- Hold rx_valid high for 20 cycles with rx_data=0xA5 and no errors -> exactly one entry; m_data=0xA5, tags 0, level=1; pop with m_ready -> level=0, m_valid=0.
- Raise parity_error, then rx_valid, with rx_data=0x3C -> entry {fe=0, pe=1, 0x3C}. Raise frame_error alone with rx_data=0x00 -> entry {fe=1, pe=0}. Repeat with DROP_ERRORED=1 -> nothing stored, err_cnt=2.
- 17 events with data 0x00..0x10, m_ready=0, DEPTH=16 -> level=16, almost_full=1 from the 12th entry, 17th dropped, overflow=1, drop_cnt=1. Drain all 16 -> data 0x00..0x0F in order.
- FIFO full, event and pop in the same cycle -> push accepted, level stays 16, new byte read last. Then ovf_clr -> overflow=0, drop_cnt=0.
- 40 push/pop interleaved events crossing pointer wrap twice -> FIFO order preserved, level never exceeds 16.
- Assert rst_n low with 5 entries stored and rx_valid high -> level=0, m_valid=0, overflow=0 immediately. After release, no event is generated until rx_valid falls and rises again.
